// File: rtl/bram_dp_arbiter_pkg.sv
// Shared constants and types for the dual-port BRAM arbiter.
package bram_arb_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    // Per-port record of a read in flight: which requester gets the data next cycle.
    typedef struct packed {
        logic       vld;
        logic [2:0] idx;
    } tag_t;

endpackage

// File: rtl/bram_dp_arbiter_if.sv
// Requester bus and BRAM port bundle for bram_dp_arbiter.
//
// Handshake: requester i transfers a request in any cycle where REQ_VALID[i] and
// REQ_READY[i] are both 1. REQ_READY is combinational from the request inputs and
// registered arbiter state, so a requester must never derive REQ_VALID from
// REQ_READY, and must hold WE/ADDR/WDATA stable while VALID=1 and READY=0.
// RSP_VALID[i] is a one-cycle pulse with no back-pressure; RSP_PORT[i] picks the
// half of RSP_RDATA carrying that requester's data (0 = low half, 1 = high half).
interface bram_dp_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = bram_arb_pkg::ADDR_W,
    parameter int DATA_W = bram_arb_pkg::DATA_W
);

    logic [NREQ-1:0]        REQ_VALID;
    logic [NREQ-1:0]        REQ_READY;
    logic [NREQ-1:0]        REQ_WE;
    logic [NREQ*ADDR_W-1:0] REQ_ADDR;
    logic [NREQ*DATA_W-1:0] REQ_WDATA;
    logic [NREQ-1:0]        RSP_VALID;
    logic [2*DATA_W-1:0]    RSP_RDATA;
    logic [NREQ-1:0]        RSP_PORT;

    logic [ADDR_W-1:0]      A0, A1;
    logic [DATA_W-1:0]      D0, D1;
    logic                   WE0, WE1;
    logic [DATA_W-1:0]      WEM0, WEM1;
    logic                   CE0, CE1;
    logic [DATA_W-1:0]      Q0, Q1;

    // Arbiter side.
    modport slave (
        input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, Q0, Q1,
        output REQ_READY, RSP_VALID, RSP_RDATA, RSP_PORT,
        output A0, D0, WE0, WEM0, CE0, A1, D1, WE1, WEM1, CE1
    );

    // Requesters plus BRAM side.
    modport master (
        output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, Q0, Q1,
        input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_PORT,
        input  A0, D0, WE0, WEM0, CE0, A1, D1, WE1, WEM1, CE1
    );

endinterface

// File: rtl/bram_dp_arbiter_rr_pick.sv
// Cyclic priority picker: first set bit of req at or after start, wrapping upward.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   start,
    output logic            found,
    output logic [IW-1:0]   idx
);

    int j;

    // Scan from the far end back to start so the closest candidate is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(start) + k) % NREQ;
            if (req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/bram_dp_arbiter.sv
// Two-grant-per-cycle round-robin arbiter sharing one dual-port BRAM among NREQ
// requesters, with same-address write collision blocking and read response routing.
module bram_dp_arbiter #(
    parameter  int NREQ   = 4,
    parameter  int ADDR_W = bram_arb_pkg::ADDR_W,
    parameter  int DATA_W = bram_arb_pkg::DATA_W,
    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    bram_dp_arbiter_if.slave    bus,
    output logic [IW-1:0]       dbg_rr_ptr
);

    import bram_arb_pkg::tag_t;

    logic [ADDR_W-1:0] addr  [NREQ];
    logic [DATA_W-1:0] wdata [NREQ];

    logic [IW-1:0]   rr_ptr, rr_next;
    logic [IW-1:0]   idx0, idx1, start1;
    logic            found0, found1, collide, grant0, grant1;
    logic [NREQ-1:0] mask1;
    tag_t            tag0, tag1;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(NREQ - 1)) ? '0 : i + IW'(1);
    endfunction

    // Unpack the flattened request payload buses.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr[i]  = bus.REQ_ADDR[i*ADDR_W +: ADDR_W];
            wdata[i] = bus.REQ_WDATA[i*DATA_W +: DATA_W];
        end
    end

    rr_pick #(.NREQ(NREQ)) u_pick0 (
        .req   (bus.REQ_VALID),
        .start (rr_ptr),
        .found (found0),
        .idx   (idx0)
    );

    // Port 1 searches after the port-0 winner and never sees it again.
    always_comb begin
        mask1       = bus.REQ_VALID;
        mask1[idx0] = 1'b0;
        start1      = next_idx(idx0);
    end

    rr_pick #(.NREQ(NREQ)) u_pick1 (
        .req   (mask1),
        .start (start1),
        .found (found1),
        .idx   (idx1)
    );

    // Drop the port-1 candidate on a same-address access involving a write; reads may share.
    always_comb begin
        collide = (addr[idx0] == addr[idx1]) && (bus.REQ_WE[idx0] || bus.REQ_WE[idx1]);
        grant0  = found0 && !RST;
        grant1  = found1 && !collide && !RST;
        for (int i = 0; i < NREQ; i++) begin
            bus.REQ_READY[i] = (grant0 && (idx0 == IW'(i))) || (grant1 && (idx1 == IW'(i)));
        end
    end

    // BRAM port drive; idle ports are held at zero.
    always_comb begin
        bus.CE0  = grant0;
        bus.WE0  = grant0 && bus.REQ_WE[idx0];
        bus.A0   = grant0 ? addr[idx0]  : '0;
        bus.D0   = grant0 ? wdata[idx0] : '0;
        bus.WEM0 = grant0 ? '1 : '0;
        bus.CE1  = grant1;
        bus.WE1  = grant1 && bus.REQ_WE[idx1];
        bus.A1   = grant1 ? addr[idx1]  : '0;
        bus.D1   = grant1 ? wdata[idx1] : '0;
        bus.WEM1 = grant1 ? '1 : '0;
    end

    // Pointer moves just past the last requester served; port 1 is always served later.
    always_comb begin
        rr_next = rr_ptr;
        if (grant1) begin
            rr_next = next_idx(idx1);
        end else if (grant0) begin
            rr_next = next_idx(idx0);
        end
    end

    // Round-robin pointer and per-port read tags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr <= '0;
            tag0   <= '0;
            tag1   <= '0;
        end else begin
            rr_ptr   <= rr_next;
            tag0.vld <= grant0 && !bus.REQ_WE[idx0];
            tag0.idx <= 3'(idx0);
            tag1.vld <= grant1 && !bus.REQ_WE[idx1];
            tag1.idx <= 3'(idx1);
        end
    end

    // Route each returning read to its requester; nothing is reported while in reset.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            bus.RSP_VALID[i] = !RST && ((tag0.vld && (tag0.idx == 3'(i))) ||
                                        (tag1.vld && (tag1.idx == 3'(i))));
            bus.RSP_PORT[i]  = !RST && tag1.vld && (tag1.idx == 3'(i));
        end
        bus.RSP_RDATA[0 +: DATA_W]      = tag0.vld ? bus.Q0 : '0;
        bus.RSP_RDATA[DATA_W +: DATA_W] = tag1.vld ? bus.Q1 : '0;
    end

    assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_bram_dp_arbiter.sv
// Directed bench for bram_dp_arbiter with a behavioural BRAM_512x32 model.
module tb_bram_dp_arbiter;

    localparam int NREQ = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_rr_ptr;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    bram_dp_arbiter_if #(.NREQ(NREQ)) bus ();

    bram_dp_arbiter #(.NREQ(NREQ)) dut (
        .CLK        (clk),
        .RST        (rst),
        .bus        (bus),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // BRAM model: one-cycle read latency per port; preload constants while reset is high.
    logic [31:0] mem [512];
    always @(posedge clk) begin
        if (rst) begin
            mem[9'h010] <= 32'hDEADBEEF;
            mem[9'h000] <= 32'h11112222;
            mem[9'h005] <= 32'h55AA55AA;
            mem[9'h100] <= 32'hC0DE0100;
            mem[9'h101] <= 32'hC0DE0101;
            mem[9'h102] <= 32'hC0DE0102;
            mem[9'h103] <= 32'hC0DE0103;
        end else begin
            if (bus.CE0) begin
                if (bus.WE0) mem[bus.A0] <= (bus.D0 & bus.WEM0) | (mem[bus.A0] & ~bus.WEM0);
                bus.Q0 <= mem[bus.A0];
            end
            if (bus.CE1) begin
                if (bus.WE1) mem[bus.A1] <= (bus.D1 & bus.WEM1) | (mem[bus.A1] & ~bus.WEM1);
                bus.Q1 <= mem[bus.A1];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_all;
        bus.REQ_VALID = '0;
        bus.REQ_WE    = '0;
        bus.REQ_ADDR  = '0;
        bus.REQ_WDATA = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [8:0] a, input logic [31:0] d);
        bus.REQ_VALID[i]        = 1'b1;
        bus.REQ_WE[i]           = we;
        bus.REQ_ADDR[i*9 +: 9]  = a;
        bus.REQ_WDATA[i*32 +: 32] = d;
    endtask

    task automatic drop_req(input int i);
        bus.REQ_VALID[i] = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int          grants [NREQ];
    logic [3:0]  prev_ready;
    logic [31:0] exp_lo, exp_hi;

    initial begin
        clr_all();
        bus.REQ_VALID = '1;

        // Reset state with every requester asking.
        tick();
        tick();
        @(negedge clk);
        check("rst_ready", 64'(bus.REQ_READY), 64'h0);
        check("rst_rspv",  64'(bus.RSP_VALID), 64'h0);
        check("rst_ce",    64'({bus.CE1, bus.CE0, bus.WE1, bus.WE0}), 64'h0);
        check("rst_ptr",   64'(dbg_rr_ptr), 64'h0);
        clr_all();
        tick();
        rst = 1'b0;

        // 1: single read by req0.
        set_req(0, 1'b0, 9'h010, 32'h0);
        exp_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        check("t1_ready", 64'(bus.REQ_READY), 64'h1);
        check("t1_port0", 64'({bus.CE0, bus.WE0, bus.A0}), 64'({1'b1, 1'b0, 9'h010}));
        check("t1_ce1",   64'(bus.CE1), 64'h0);
        tick();
        clr_all();
        @(negedge clk);
        check("t1_rspv",  64'(bus.RSP_VALID), 64'h1);
        check("t1_rport", 64'(bus.RSP_PORT), 64'h0);
        check("t1_data",  64'(bus.RSP_RDATA[31:0]), 64'(exp_q.pop_front()));

        // 2: req1 writes, req2 reads, both in one cycle (pointer is 1).
        tick();
        set_req(1, 1'b1, 9'h1FF, 32'hA5A5A5A5);
        set_req(2, 1'b0, 9'h000, 32'h0);
        exp_q.push_back(32'h11112222);
        @(negedge clk);
        check("t2_ready", 64'(bus.REQ_READY), 64'h6);
        check("t2_p0",    64'({bus.CE0, bus.WE0, bus.A0}), 64'({1'b1, 1'b1, 9'h1FF}));
        check("t2_p1",    64'({bus.CE1, bus.WE1, bus.A1}), 64'({1'b1, 1'b0, 9'h000}));
        tick();
        clr_all();
        @(negedge clk);
        check("t2_rspv",  64'(bus.RSP_VALID), 64'h4);
        check("t2_rport", 64'(bus.RSP_PORT), 64'h4);
        check("t2_data",  64'(bus.RSP_RDATA[63:32]), 64'(exp_q.pop_front()));
        tick();
        set_req(3, 1'b0, 9'h1FF, 32'h0);
        exp_q.push_back(32'hA5A5A5A5);
        @(negedge clk);
        check("t2_rb_ready", 64'(bus.REQ_READY), 64'h8);
        tick();
        clr_all();
        @(negedge clk);
        check("t2_rb_data", 64'(bus.RSP_RDATA[31:0]), 64'(exp_q.pop_front()));

        // 3: write collision on 0x020 (pointer is 0).
        tick();
        set_req(0, 1'b1, 9'h020, 32'h00000A0A);
        set_req(1, 1'b1, 9'h020, 32'h0000B1B1);
        @(negedge clk);
        check("t3_ready_t0", 64'(bus.REQ_READY), 64'h1);
        check("t3_ce1_t0",   64'(bus.CE1), 64'h0);
        tick();
        drop_req(0);
        @(negedge clk);
        check("t3_ready_t1", 64'(bus.REQ_READY), 64'h2);
        check("t3_p0_t1",    64'({bus.CE0, bus.WE0, bus.D0}), 64'({1'b1, 1'b1, 32'h0000B1B1}));
        tick();
        clr_all();
        set_req(2, 1'b0, 9'h020, 32'h0);
        exp_q.push_back(32'h0000B1B1);
        @(negedge clk);
        check("t3_rd_ready", 64'(bus.REQ_READY), 64'h4);
        tick();
        clr_all();
        @(negedge clk);
        check("t3_final", 64'(bus.RSP_RDATA[31:0]), 64'(exp_q.pop_front()));

        // 4: fairness, all four hold reads for 8 cycles from pointer 0.
        tick();
        do_reset();
        @(negedge clk);
        check("t4_ptr0", 64'(dbg_rr_ptr), 64'h0);
        tick();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'b0, 9'(9'h100 + i), 32'h0);
            grants[i] = 0;
        end
        prev_ready = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("t4_ready_c%0d", c), 64'(bus.REQ_READY), (c % 2 == 0) ? 64'h3 : 64'hC);
            for (int i = 0; i < NREQ; i++) grants[i] += int'(bus.REQ_READY[i]);
            if (c > 0) begin
                exp_lo = (c % 2 == 1) ? 32'hC0DE0100 : 32'hC0DE0102;
                exp_hi = (c % 2 == 1) ? 32'hC0DE0101 : 32'hC0DE0103;
                check($sformatf("t4_rspv_c%0d", c), 64'(bus.RSP_VALID), 64'(prev_ready));
                check($sformatf("t4_data_c%0d", c), bus.RSP_RDATA, {exp_hi, exp_lo});
            end
            prev_ready = bus.REQ_READY;
            tick();
        end
        clr_all();
        @(negedge clk);
        check("t4_rspv_last", 64'(bus.RSP_VALID), 64'hC);
        for (int i = 0; i < NREQ; i++) check($sformatf("t4_grants%0d", i), 64'(grants[i]), 64'd4);

        // 5: reset while req3's read is in flight.
        tick();
        set_req(3, 1'b0, 9'h005, 32'h0);
        @(negedge clk);
        check("t5_ready", 64'(bus.REQ_READY), 64'h8);
        tick();
        clr_all();
        rst = 1'b1;
        @(negedge clk);
        check("t5_rspv_rst", 64'(bus.RSP_VALID), 64'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_rspv_post", 64'(bus.RSP_VALID), 64'h0);
        check("t5_ptr", 64'(dbg_rr_ptr), 64'h0);
        tick();
        set_req(3, 1'b0, 9'h010, 32'h0);
        set_req(0, 1'b0, 9'h000, 32'h0);
        @(negedge clk);
        check("t5_ready2", 64'(bus.REQ_READY), 64'h9);
        check("t5_a0",     64'({bus.CE0, bus.A0, bus.A1}), 64'({1'b1, 9'h000, 9'h010}));
        tick();
        clr_all();

        // 6: two reads of 0x005 in one cycle (pointer is 0).
        tick();
        set_req(0, 1'b0, 9'h005, 32'h0);
        set_req(2, 1'b0, 9'h005, 32'h0);
        exp_q.push_back(32'h55AA55AA);
        @(negedge clk);
        check("t6_ready", 64'(bus.REQ_READY), 64'h5);
        tick();
        clr_all();
        @(negedge clk);
        check("t6_rspv",  64'(bus.RSP_VALID), 64'h5);
        check("t6_rport", 64'(bus.RSP_PORT), 64'h4);
        exp_lo = exp_q.pop_front();
        check("t6_data",  bus.RSP_RDATA, {exp_lo, exp_lo});

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
